data_mem_resp: RTL and testbench

Responder for the single-cycle CPU's data-memory port: it answers loads and stores driven by the datapath on Mem_WrAddr/Mem_WrData, and returns ReadData in the same cycle. It contains word-organised RAM with byte/halfword/word access and sign/zero extension. It also contains a small MMIO block with a GPIO register, a free-running 64-bit cycle timer with compare/interrupt, and a sticky misalignment status. It sits between the CPU core and the board pins in the top level.

---
 rtl/data_mem_resp.sv | 155 +++++++++++++++
 tb/tb_data_mem_resp.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
// Data-memory responder for the single-cycle core: word-organised RAM with
// byte/half/word access, plus a small MMIO block (GPIO, 64-bit timer with
// compare, sticky status). Loads are combinational; stores commit on the edge.
`timescale 1ns/1ps
module data_mem_resp #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic [7:0]  gpio_out,
  output logic        timer_irq
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  logic [7:0]  gpio_q;
  logic [63:0] mtime_q;
  logic [31:0] hi_shadow_q;
  logic [31:0] mtimecmp_q;
  logic [1:0]  status_q;
  logic [1:0]  status_d;

  logic          ram_hit, mmio_hit, mmio_ok;
  logic [31:0]   mmio_off;
  logic          is_byte, is_half, is_word, misalign, fault;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_rdata, ram_load, mmio_rdata, wlane;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [3:0]    be;
  logic          mmio_wr, mtime_lo_rd;
  logic [1:0]    w1c, status_set;

  // Address decode, alignment and fault detection.
  always_comb begin
    ram_hit  = Mem_WrAddr < RAM_BYTES;
    mmio_off = Mem_WrAddr - MMIO_BASE;
    mmio_hit = (Mem_WrAddr >= MMIO_BASE) && (mmio_off < 32'h14);
    is_byte  = (Funct3 == 3'b000) || (Funct3 == 3'b100);
    is_half  = (Funct3 == 3'b001) || (Funct3 == 3'b101);
    is_word  = (Funct3 == 3'b010);
    misalign = (is_half && Mem_WrAddr[0]) || (is_word && (Mem_WrAddr[1:0] != 2'b00));
    // Non-word MMIO accesses are silently dropped, so only word MMIO can fault.
    fault    = (MemRead || MemWrite) && misalign && (ram_hit || (mmio_hit && is_word));
    mmio_ok  = mmio_hit && is_word && (Mem_WrAddr[1:0] == 2'b00);
    mmio_wr  = MemWrite && mmio_ok;
    mtime_lo_rd = MemRead && mmio_ok && (mmio_off[4:2] == 3'd1);
    ram_idx  = Mem_WrAddr[AW+1:2];
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    be    = 4'b0000;
    wlane = Mem_WrData;
    if (MemWrite && ram_hit && !misalign) begin
      case (Funct3)
        3'b000:  be = 4'b0001 << Mem_WrAddr[1:0];
        3'b001:  be = Mem_WrAddr[1] ? 4'b1100 : 4'b0011;
        3'b010:  be = 4'b1111;
        default: be = 4'b0000;
      endcase
    end
    if (is_byte)      wlane = {4{Mem_WrData[7:0]}};
    else if (is_half) wlane = {2{Mem_WrData[15:0]}};
  end

  // RAM write port; contents are not reset, but stores are blocked during reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[ram_idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  // RAM load lane select and sign/zero extension.
  always_comb begin
    ram_rdata = mem[ram_idx];
    case (Mem_WrAddr[1:0])
      2'd0:    rd_byte = ram_rdata[7:0];
      2'd1:    rd_byte = ram_rdata[15:8];
      2'd2:    rd_byte = ram_rdata[23:16];
      default: rd_byte = ram_rdata[31:24];
    endcase
    rd_half = Mem_WrAddr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (Funct3)
      3'b000:  ram_load = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  ram_load = {24'b0, rd_byte};
      3'b001:  ram_load = {{16{rd_half[15]}}, rd_half};
      3'b101:  ram_load = {16'b0, rd_half};
      3'b010:  ram_load = ram_rdata;
      default: ram_load = 32'b0;
    endcase
    if (misalign) ram_load = 32'b0;
  end

  // MMIO read mux and final read-data select.
  always_comb begin
    case (mmio_off[4:2])
      3'd0:    mmio_rdata = {24'b0, gpio_q};
      3'd1:    mmio_rdata = mtime_q[31:0];
      3'd2:    mmio_rdata = hi_shadow_q;
      3'd3:    mmio_rdata = mtimecmp_q;
      3'd4:    mmio_rdata = {30'b0, status_q};
      default: mmio_rdata = 32'b0;
    endcase
    if (ram_hit)      ReadData = ram_load;
    else if (mmio_ok) ReadData = mmio_rdata;
    else              ReadData = 32'b0;
  end

  // Status next state: set conditions win over a same-edge write-1-to-clear.
  always_comb begin
    status_set = {fault, mtime_q[31:0] == mtimecmp_q};
    w1c        = (mmio_wr && (mmio_off[4:2] == 3'd4)) ? Mem_WrData[1:0] : 2'b00;
    status_d   = status_set | (status_q & ~w1c);
  end

  // MMIO registers and free-running timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_q      <= 8'h00;
      mtime_q     <= 64'd0;
      hi_shadow_q <= 32'd0;
      mtimecmp_q  <= 32'hFFFF_FFFF;
      status_q    <= 2'b00;
    end else begin
      mtime_q  <= mtime_q + 64'd1;
      status_q <= status_d;
      // Latching the high word on a low-word read gives a coherent 64-bit sample.
      if (mtime_lo_rd) hi_shadow_q <= mtime_q[63:32];
      if (mmio_wr) begin
        case (mmio_off[4:2])
          3'd0:    gpio_q     <= Mem_WrData[7:0];
          3'd3:    mtimecmp_q <= Mem_WrData;
          default: ;
        endcase
      end
    end
  end

  assign gpio_out  = gpio_q;
  assign timer_irq = status_q[0];

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp with a scoreboard queue of expected values.
`timescale 1ns/1ps
module tb_data_mem_resp;

  localparam logic [2:0]  LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [31:0] A_GPIO = 32'h2000, A_LO = 32'h2004, A_HI = 32'h2008;
  localparam logic [31:0] A_CMP  = 32'h200C, A_ST = 32'h2010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [2:0]  Funct3 = 3'b010;
  logic [31:0] Mem_WrAddr = 32'd0;
  logic [31:0] Mem_WrData = 32'd0;
  logic [31:0] ReadData;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];
  logic [63:0] tb_mtime;
  logic [31:0] t;

  data_mem_resp #(.DEPTH_WORDS(64), .MMIO_BASE(32'h0000_2000)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .Funct3     (Funct3),
    .Mem_WrAddr (Mem_WrAddr),
    .Mem_WrData (Mem_WrData),
    .ReadData   (ReadData),
    .gpio_out   (gpio_out),
    .timer_irq  (timer_irq)
  );

  always #5 clk = ~clk;

  // Reference timer count: zero in reset, +1 per edge afterwards.
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_mtime <= 64'd0;
    else        tb_mtime <= tb_mtime + 64'd1;
  end

  task automatic expect_v(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed %h, scoreboard had no expected value", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemWrite   = we;
    MemRead    = re;
    Funct3     = f3;
    Mem_WrAddr = a;
    Mem_WrData = d;
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] e);
    drive(1'b0, 1'b1, f3, a, 32'd0);
    expect_v(e);
    #1 check(tag, ReadData);
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, f3, a, d);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, LW, 32'h0000_4000, 32'd0);
  endtask

  task automatic out_chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    expect_v(e);
    check(tag, obs);
  endtask

  initial begin
    #100_000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    out_chk("rst_gpio", {24'b0, gpio_out}, 32'h0);
    out_chk("rst_irq", {31'b0, timer_irq}, 32'h0);
    load("rst_cmp", LW, A_CMP, 32'hFFFF_FFFF);
    load("rst_status", LW, A_ST, 32'h0);
    load("rst_mtlo", LW, A_LO, 32'h0);

    // Release and read the timer in the 100th cycle.
    drive(1'b0, 1'b0, LW, 32'h0000_4000, 32'd0);
    reset = 1'b1;
    repeat (98) @(negedge clk);
    load("mtlo_99", LW, A_LO, 32'd99);
    load("mthi_0", LW, A_HI, 32'd0);

    // RAM word/byte/half access and extension.
    store(LW, 32'h10, 32'h8000_00F1);
    load("lb", LB, 32'h10, 32'hFFFF_FFF1);
    load("lbu", LBU, 32'h10, 32'h0000_00F1);
    load("lh", LH, 32'h10, 32'h0000_00F1);
    load("lhu", LHU, 32'h10, 32'h0000_00F1);
    load("lw", LW, 32'h10, 32'h8000_00F1);
    store(LB, 32'h13, 32'h0000_007F);
    load("lw_after_sb", LW, 32'h10, 32'h7F00_00F1);
    load("lb_13", LB, 32'h13, 32'h0000_007F);
    load("lh_12", LH, 32'h12, 32'h0000_7F00);
    load("lh_neg", LH, 32'h10, 32'h0000_00F1);
    store(LH, 32'h14, 32'h0000_9234);
    load("lh_sext", LH, 32'h14, 32'hFFFF_9234);
    load("lhu_zext", LHU, 32'h14, 32'h0000_9234);
    load("f3_011", 3'b011, 32'h10, 32'h0);

    // Misaligned accesses.
    store(LH, 32'h11, 32'h0000_BEEF);
    load("lw_after_sh_mis", LW, 32'h10, 32'h7F00_00F1);
    load("lw_misal", LW, 32'h12, 32'h0);
    load("status_misal", LW, A_ST, 32'h2);
    store(LW, A_ST, 32'h2);
    load("status_clr", LW, A_ST, 32'h0);

    // GPIO and unmapped space.
    store(LW, A_GPIO, 32'h0000_00A5);
    idle();
    #1 out_chk("gpio_sw", {24'b0, gpio_out}, 32'hA5);
    store(LB, A_GPIO, 32'h0000_003C);
    idle();
    #1 out_chk("gpio_sb_ign", {24'b0, gpio_out}, 32'hA5);
    load("gpio_rd", LW, A_GPIO, 32'hA5);
    load("unmapped", LW, 32'h0000_4000, 32'h0);
    load("mmio_lb", LBU, A_GPIO, 32'h0);

    // Live timer low word against the reference count.
    drive(1'b0, 1'b1, LW, A_LO, 32'd0);
    expect_v(tb_mtime[31:0]);
    #1 check("mtlo_live", ReadData);

    // Compare match five edges after the MTIMECMP store edge.
    @(negedge clk);
    t = tb_mtime[31:0];
    MemWrite = 1'b1; MemRead = 1'b0; Funct3 = LW; Mem_WrAddr = A_CMP; Mem_WrData = t + 32'd5;
    repeat (5) idle();
    #1 out_chk("irq_pre", {31'b0, timer_irq}, 32'h0);
    idle();
    #1 out_chk("irq_set", {31'b0, timer_irq}, 32'h1);
    repeat (3) idle();
    #1 out_chk("irq_hold", {31'b0, timer_irq}, 32'h1);
    load("status_pend", LW, A_ST, 32'h1);
    store(LW, A_ST, 32'h1);
    idle();
    #1 out_chk("irq_clr", {31'b0, timer_irq}, 32'h0);

    // Write-1-to-clear coinciding with a match: set wins.
    @(negedge clk);
    t = tb_mtime[31:0];
    MemWrite = 1'b1; MemRead = 1'b0; Funct3 = LW; Mem_WrAddr = A_CMP; Mem_WrData = t + 32'd3;
    idle();
    idle();
    store(LW, A_ST, 32'h1);
    idle();
    #1 out_chk("irq_set_wins", {31'b0, timer_irq}, 32'h1);
    store(LW, A_ST, 32'h1);
    idle();
    #1 out_chk("irq_clr2", {31'b0, timer_irq}, 32'h0);

    // Low-word wrap: the shadow captures the new high word.
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b0;
    force dut.mtime_q = 64'h0000_0000_FFFF_FFFE;
    #1 release dut.mtime_q;
    idle();
    load("wrap_lo", LW, A_LO, 32'h0);
    load("wrap_hi", LW, A_HI, 32'h1);

    // Reset mid-run with a GPIO store in flight.
    load("gpio_before_rst", LW, A_GPIO, 32'hA5);
    @(negedge clk);
    MemWrite = 1'b1; MemRead = 1'b0; Funct3 = LW; Mem_WrAddr = A_GPIO; Mem_WrData = 32'h5A;
    #2 reset = 1'b0;
    #1;
    out_chk("rst2_gpio_now", {24'b0, gpio_out}, 32'h0);
    out_chk("rst2_irq", {31'b0, timer_irq}, 32'h0);
    @(negedge clk);
    MemWrite = 1'b0;
    reset = 1'b1;
    #1 out_chk("rst2_gpio_rel", {24'b0, gpio_out}, 32'h0);
    load("rst2_cmp", LW, A_CMP, 32'hFFFF_FFFF);
    load("rst2_hi", LW, A_HI, 32'h0);
    load("rst2_status", LW, A_ST, 32'h0);
    idle();
    #1 out_chk("rst2_gpio_after", {24'b0, gpio_out}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
